// File: rtl/coin_acceptor_pkg.sv
// Shared vending types: coin codes, acceptor FSM states and sensor/code helpers.
package coin_acceptor_pkg;

    localparam int unsigned NUM_SENSORS = 3;
    localparam int unsigned CODE_W      = 2;

    // Coin code handed to the vending FSM.
    typedef enum logic [CODE_W-1:0] {
        COIN_NONE       = 2'b00,
        COIN_FIVE       = 2'b01,
        COIN_TEN        = 2'b10,
        COIN_TWENTYFIVE = 2'b11
    } coin_code_e;

    // Coin acceptor FSM states.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ACTIVE     = 3'd1,
        ST_EMIT       = 3'd2,
        ST_GAP        = 3'd3,
        ST_REJECT     = 3'd4,
        ST_WAIT_CLEAR = 3'd5,
        ST_JAM        = 3'd6
    } ca_state_e;

    // Sensor bit order in all masks: [0]=five, [1]=ten, [2]=twenty-five.
    function automatic logic [NUM_SENSORS-1:0] code_to_mask(input coin_code_e code);
        logic [NUM_SENSORS-1:0] mask;
        case (code)
            COIN_FIVE:       mask = 3'b001;
            COIN_TEN:        mask = 3'b010;
            COIN_TWENTYFIVE: mask = 3'b100;
            default:         mask = 3'b000;
        endcase
        return mask;
    endfunction

    // Only meaningful for one-hot masks; anything else maps to NONE.
    function automatic coin_code_e mask_to_code(input logic [NUM_SENSORS-1:0] mask);
        coin_code_e code;
        case (mask)
            3'b001:  code = COIN_FIVE;
            3'b010:  code = COIN_TEN;
            3'b100:  code = COIN_TWENTYFIVE;
            default: code = COIN_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/coin_acceptor_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce filter for one sensor.
module coin_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic level_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronizer shift and debounce counter: toggle after DEBOUNCE_CYCLES disagreeing cycles.
    always_comb begin
        sync_d  = {sync_q[0], raw_i};
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces three slot sensors and qualifies each coin episode into
// a single credit, a reject pulse, or a jam condition.
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned JAM_CYCLES      = 1000,
    parameter int unsigned GAP_CYCLES      = 2     // must be >= 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sense_5,
    input  logic              sense_10,
    input  logic              sense_25,
    output logic [CODE_W-1:0] coin_in,
    output logic              reject_out,
    output logic              jam_out,
    output logic              busy_out
);

    localparam int unsigned JW = $clog2(JAM_CYCLES + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    logic [NUM_SENSORS-1:0] raw;
    logic [NUM_SENSORS-1:0] deb;
    logic                   any_high;
    logic                   multi_high;
    logic                   other_high;

    ca_state_e     state_q, state_d;
    coin_code_e    code_q, code_d;
    logic [JW-1:0] jam_cnt_q, jam_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    coin_code_e    coin_q, coin_d;
    logic          reject_q, reject_d;
    logic          jam_q, jam_d;
    logic          busy_q, busy_d;

    assign raw = {sense_25, sense_10, sense_5};

    // One synchronizer/debounce filter per sensor.
    for (genvar i = 0; i < int'(NUM_SENSORS); i++) begin : g_deb
        coin_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clock   (clock),
            .reset   (reset),
            .raw_i   (raw[i]),
            .level_o (deb[i])
        );
    end

    assign any_high   = |deb;
    assign multi_high = (deb[0] & deb[1]) | (deb[0] & deb[2]) | (deb[1] & deb[2]);
    assign other_high = |(deb & ~code_to_mask(code_q));

    // Next-state, counters and registered output values.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        jam_cnt_d = jam_cnt_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (multi_high) begin
                    state_d = ST_REJECT;
                end else if (any_high) begin
                    state_d   = ST_ACTIVE;
                    code_d    = mask_to_code(deb);
                    jam_cnt_d = '0;
                end
            end
            ST_ACTIVE: begin
                if (jam_cnt_q < JW'(JAM_CYCLES)) begin
                    jam_cnt_d = jam_cnt_q + JW'(1);
                end
                // Jam outranks a second sensor seen in the same cycle.
                if (jam_cnt_q >= JW'(JAM_CYCLES)) begin
                    state_d = ST_JAM;
                end else if (!any_high) begin
                    state_d = ST_EMIT;
                end else if (other_high) begin
                    state_d = ST_REJECT;
                end
            end
            ST_EMIT: begin
                state_d   = ST_GAP;
                gap_cnt_d = '0;
            end
            ST_GAP: begin
                if (gap_cnt_q >= GW'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            ST_REJECT: begin
                state_d = ST_WAIT_CLEAR;
            end
            ST_WAIT_CLEAR, ST_JAM: begin
                if (!any_high) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Credit lands in the cycle after EMIT is entered; status flags track the next state.
        coin_d   = (state_q == ST_EMIT) ? code_q : COIN_NONE;
        reject_d = (state_d == ST_REJECT);
        jam_d    = (state_d == ST_JAM);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            code_q    <= COIN_NONE;
            jam_cnt_q <= '0;
            gap_cnt_q <= '0;
            coin_q    <= COIN_NONE;
            reject_q  <= 1'b0;
            jam_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            jam_cnt_q <= jam_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            coin_q    <= coin_d;
            reject_q  <= reject_d;
            jam_q     <= jam_d;
            busy_q    <= busy_d;
        end
    end

    assign coin_in    = coin_q;
    assign reject_out = reject_q;
    assign jam_out    = jam_q;
    assign busy_out   = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4, GAP_CYCLES=2, JAM_CYCLES=50.
module tb_coin_acceptor;

    logic       clock;
    logic       reset;
    logic       sense_5;
    logic       sense_10;
    logic       sense_25;
    logic [1:0] coin_in;
    logic       reject_out;
    logic       jam_out;
    logic       busy_out;

    int n_cmp;
    int n_fail;

    // Per-window observation tallies.
    int         cyc_idx;
    int         first_coin_idx;
    int         n_coin;
    logic [1:0] last_coin;
    int         n_rej;
    int         n_jam;
    int         n_busy;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (4),
        .JAM_CYCLES      (50),
        .GAP_CYCLES      (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sense_5    (sense_5),
        .sense_10   (sense_10),
        .sense_25   (sense_25),
        .coin_in    (coin_in),
        .reject_out (reject_out),
        .jam_out    (jam_out),
        .busy_out   (busy_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_obs();
        cyc_idx        = 0;
        first_coin_idx = -1;
        n_coin         = 0;
        last_coin      = 2'b00;
        n_rej          = 0;
        n_jam          = 0;
        n_busy         = 0;
    endtask

    // Advance n clocks, sampling outputs 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            cyc_idx++;
            if (coin_in != 2'b00) begin
                n_coin++;
                last_coin = coin_in;
                if (first_coin_idx < 0) first_coin_idx = cyc_idx;
            end
            if (reject_out) n_rej++;
            if (jam_out)    n_jam++;
            if (busy_out)   n_busy++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sense_5 = 1'b0; sense_10 = 1'b0; sense_25 = 1'b0;
        step(3);
        n_cmp++;
        if ({coin_in, reject_out, jam_out, busy_out} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_during: outputs=%b expected=00000", {coin_in, reject_out, jam_out, busy_out});
        end
        reset = 1'b0;
        step(1);
        n_cmp++;
        if ({coin_in, reject_out, jam_out, busy_out} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_after: outputs=%b expected=00000", {coin_in, reject_out, jam_out, busy_out});
        end
    endtask

    task automatic test_coin_ten();
        sense_10 = 1'b1;
        step(20);
        sense_10 = 1'b0;
        clear_obs();
        step(20);
        // Falling sample is edge 1 of the window; credit 7 clocks later.
        n_cmp++;
        if (first_coin_idx !== 8) begin
            n_fail++;
            $display("FAIL ten_latency: got edge %0d expected 8", first_coin_idx);
        end
        n_cmp++;
        if (n_coin !== 1) begin
            n_fail++;
            $display("FAIL ten_count: got %0d expected 1", n_coin);
        end
        n_cmp++;
        if (last_coin !== 2'b10) begin
            n_fail++;
            $display("FAIL ten_code: got %b expected 10", last_coin);
        end
        n_cmp++;
        if (n_rej !== 0) begin
            n_fail++;
            $display("FAIL ten_reject: got %0d pulses expected 0", n_rej);
        end
        n_cmp++;
        if (busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL ten_idle: busy_out=%b expected 0", busy_out);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        sense_5 = 1'b1;
        step(3);
        sense_5 = 1'b0;
        step(15);
        n_cmp++;
        if (n_coin !== 0) begin
            n_fail++;
            $display("FAIL glitch_coin: got %0d coins expected 0", n_coin);
        end
        n_cmp++;
        if (n_busy !== 0) begin
            n_fail++;
            $display("FAIL glitch_busy: busy cycles %0d expected 0", n_busy);
        end
    endtask

    task automatic test_dual_reject();
        clear_obs();
        sense_5 = 1'b1; sense_25 = 1'b1;
        step(10);
        sense_5 = 1'b0; sense_25 = 1'b0;
        step(20);
        n_cmp++;
        if (n_rej !== 1) begin
            n_fail++;
            $display("FAIL dual_reject: got %0d pulses expected 1", n_rej);
        end
        n_cmp++;
        if (n_coin !== 0) begin
            n_fail++;
            $display("FAIL dual_coin: got %0d coins expected 0", n_coin);
        end
        n_cmp++;
        if (n_busy == 0) begin
            n_fail++;
            $display("FAIL dual_busy_seen: busy cycles %0d expected >0", n_busy);
        end
        n_cmp++;
        if (busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_idle: busy_out=%b expected 0", busy_out);
        end
    endtask

    task automatic test_jam();
        clear_obs();
        sense_25 = 1'b1;
        step(60);
        n_cmp++;
        if (n_jam == 0) begin
            n_fail++;
            $display("FAIL jam_rise: jam cycles %0d expected >0", n_jam);
        end
        sense_25 = 1'b0;
        step(2);
        // Debounced level is still high two clocks after release.
        n_cmp++;
        if (jam_out !== 1'b1) begin
            n_fail++;
            $display("FAIL jam_hold: jam_out=%b expected 1", jam_out);
        end
        step(13);
        n_cmp++;
        if (jam_out !== 1'b0) begin
            n_fail++;
            $display("FAIL jam_fall: jam_out=%b expected 0", jam_out);
        end
        n_cmp++;
        if (busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL jam_busy: busy_out=%b expected 0", busy_out);
        end
        n_cmp++;
        if (n_coin !== 0) begin
            n_fail++;
            $display("FAIL jam_coin: got %0d coins expected 0", n_coin);
        end
    endtask

    task automatic test_merged();
        clear_obs();
        sense_10 = 1'b1;
        step(10);
        sense_10 = 1'b0;
        step(1);
        sense_10 = 1'b1;
        step(10);
        sense_10 = 1'b0;
        step(25);
        n_cmp++;
        if (n_coin !== 1) begin
            n_fail++;
            $display("FAIL merged_count: got %0d coins expected 1", n_coin);
        end
        n_cmp++;
        if (last_coin !== 2'b10) begin
            n_fail++;
            $display("FAIL merged_code: got %b expected 10", last_coin);
        end
        n_cmp++;
        if (n_rej !== 0) begin
            n_fail++;
            $display("FAIL merged_reject: got %0d pulses expected 0", n_rej);
        end
    endtask

    task automatic test_reset_active();
        clear_obs();
        sense_5 = 1'b1;
        step(10);
        n_cmp++;
        if (busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rstact_busy: busy_out=%b expected 1", busy_out);
        end
        reset = 1'b1;
        sense_5 = 1'b0;
        step(1);
        reset = 1'b0;
        step(1);
        n_cmp++;
        if ({coin_in, reject_out, jam_out, busy_out} !== 5'b0) begin
            n_fail++;
            $display("FAIL rstact_outputs: outputs=%b expected=00000", {coin_in, reject_out, jam_out, busy_out});
        end
        step(20);
        n_cmp++;
        if (n_coin !== 0) begin
            n_fail++;
            $display("FAIL rstact_coin: got %0d coins expected 0", n_coin);
        end
    endtask

    task automatic test_held_through_reset();
        sense_25 = 1'b1;
        step(10);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        clear_obs();
        step(15);
        sense_25 = 1'b0;
        step(20);
        n_cmp++;
        if (n_coin !== 1) begin
            n_fail++;
            $display("FAIL held_count: got %0d coins expected 1", n_coin);
        end
        n_cmp++;
        if (last_coin !== 2'b11) begin
            n_fail++;
            $display("FAIL held_code: got %b expected 11", last_coin);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        sense_5 = 1'b1;
        step(8);
        sense_5 = 1'b0;
        step(12);
        sense_25 = 1'b1;
        step(8);
        sense_25 = 1'b0;
        step(15);
        n_cmp++;
        if (n_coin !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d coins expected 2", n_coin);
        end
        n_cmp++;
        if (last_coin !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_code: got %b expected 11", last_coin);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clear_obs();
        test_reset();
        test_coin_ten();
        test_glitch();
        test_dual_reject();
        test_jam();
        test_merged();
        test_reset_active();
        test_held_through_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles before a debounced sensor level changes.
REQ-002 Parameter JAM_CYCLES, default 1000: maximum cycles a single sensor may stay debounced-high before jam is declared.
REQ-003 Parameter GAP_CYCLES, default 2: post-credit lockout cycles before the next coin is qualified.
REQ-004 clock  input  1  sole clock; all state updates on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sense_5, sense_10, sense_25  input  1 each  raw asynchronous coin-slot sensors; high while a coin occludes the slot.
REQ-007 coin_in  output  2  coin code to the vending FSM: 00 none, 01 five, 10 ten, 11 twenty-five; non-zero for exactly one cycle per credited coin.
REQ-008 reject_out  output  1  one-cycle pulse when a coin event is rejected.
REQ-009 jam_out  output  1  level, high while jam is active.
REQ-010 busy_out  output  1  high in every FSM state except IDLE.

Function
REQ-011 Each sensor SHALL pass through a 2-flop synchronizer, then a debounce filter.
REQ-012 The debounced level SHALL toggle only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
REQ-013 FSM states SHALL be IDLE, ACTIVE, EMIT, GAP, REJECT, WAIT_CLEAR, JAM.
REQ-014 IDLE: none debounced -> stay; exactly one high -> ACTIVE, latch its code, clear jam counter; two or more high -> REJECT.
REQ-015 ACTIVE: all debounced low -> EMIT; any other sensor high -> REJECT; jam counter reaching JAM_CYCLES -> JAM (jam check wins over a same-cycle second sensor).
REQ-016 EMIT: coin_in equals the latched code for one cycle; next state GAP.
REQ-017 GAP: sensors ignored for GAP_CYCLES cycles, then IDLE; a sensor still high at that point is qualified normally from IDLE.
REQ-018 REJECT: reject_out high for one cycle, no credit; next state WAIT_CLEAR.
REQ-019 WAIT_CLEAR: stay until all debounced levels are low, then IDLE.
REQ-020 JAM: jam_out high; no credit; when all debounced levels are low, jam_out drops and FSM enters IDLE.
REQ-021 All outputs SHALL be registered; coin_in is non-zero only in the cycle after EMIT is entered.
REQ-022 Latency: coin_in asserts exactly 2 + DEBOUNCE_CYCLES + 1 clocks after the first edge sampling the raw sensor low, provided no gap or reject intervenes.
REQ-023 The jam counter SHALL saturate at JAM_CYCLES and never wrap.
REQ-024 At most one coin SHALL be credited per sensor high-low episode.

Reset
REQ-025 Reset SHALL clear synchronizers, debounced levels, debounce counters, jam and gap counters, and the latched code, and put the FSM in IDLE.
REQ-026 During and one cycle after reset, coin_in = 00, reject_out = 0, jam_out = 0, busy_out = 0.
REQ-027 Reset asserted mid-operation (any state) SHALL discard the pending coin without credit.
REQ-028 A sensor held high through reset SHALL be treated as a new rising event after the debounce delay.

Structure
REQ-029 The coin code typedef (NONE/FIVE/TEN/TWENTYFIVE) and the FSM state enum SHALL live in the shared vending package used by the vending FSM and benches.
REQ-030 The synchronizer plus debounce logic SHALL be a sub-module, coin_debounce, instantiated once per sensor.
REQ-031 The vending interface SHALL gain a sensor-driving clocking block for this stage.

Verification (DEBOUNCE_CYCLES=4, GAP_CYCLES=2, JAM_CYCLES=50)
REQ-032 sense_10 high 20 cycles then low -> coin_in = 10 for exactly one cycle, 7 clocks after the falling sample; reject_out stays 0.
REQ-033 sense_5 glitch high for 3 cycles -> no coin_in, busy_out stays 0.
REQ-034 sense_5 and sense_25 rise on the same cycle, held 10 cycles -> one reject_out pulse, no coin_in, IDLE after both clear.
REQ-035 sense_25 held 60 cycles -> jam_out rises, no coin_in; release -> jam_out falls, busy_out drops.
REQ-036 Two sense_10 coins of 10 cycles each, separated by 1 low cycle -> single merged episode, exactly one credit (debounce absorbs gap).
REQ-037 reset pulsed while ACTIVE on sense_5 -> no credit, all outputs 0 on the next cycle.
